// File: rtl/pipelined_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
package pipelined_rca_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Full-adder cell: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational CW-bit ripple-carry slice built from the full-adder cell.
module rca_slice
    import pipelined_rca_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    always_comb begin
        logic       c;
        logic [1:0] fa;
        // NOTE: every output gets a default first so no path can infer a latch.
        sum   = '0;
        c_msb = cin;
        c     = cin;
        for (int i = 0; i < CW; i++) begin
            if (i == CW - 1) c_msb = c;
            fa     = full_add(a[i], b[i], c);
            sum[i] = fa[0];
            c      = fa[1];
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit slice per stage,
// valid/ready flow control with a combinational, bubble-free ready chain.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_rca: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] stage_v;
    logic [STAGES-1:0] adv;

    assign b_eff   = (sub == MODE_SUB) ? ~b : b;
    assign cin_eff = (sub == MODE_ADD) ? cin : 1'b1;

    // A stage advances if out_ready is high or any stage at or after it is empty.
    always_comb begin
        logic go;
        go  = out_ready;
        adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go     = go || !stage_v[k];
            adv[k] = go;
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO  = k * CW;
        localparam int REM = WIDTH - LO;

        logic             in_v;
        logic             in_c;
        logic [REM-1:0]   in_a;
        logic [REM-1:0]   in_b;
        logic [LO+CW-1:0] s_nx;
        logic [CW-1:0]    sl_sum;
        logic             sl_cout;
        logic             sl_cmsb;
        logic             v_q;
        logic             c_q;
        logic [LO+CW-1:0] s_q;

        if (k == 0) begin : g_src
            assign in_v = in_valid;
            assign in_c = cin_eff;
            assign in_a = a;
            assign in_b = b_eff;
            assign s_nx = sl_sum;
        end else begin : g_src
            assign in_v = g_st[k-1].v_q;
            assign in_c = g_st[k-1].c_q;
            assign in_a = g_st[k-1].g_hi.ah_q;
            assign in_b = g_st[k-1].g_hi.bh_q;
            assign s_nx = {sl_sum, g_st[k-1].s_q};
        end

        rca_slice #(.CW(CW)) u_slice (
            .a     (in_a[CW-1:0]),
            .b     (in_b[CW-1:0]),
            .cin   (in_c),
            .sum   (sl_sum),
            .cout  (sl_cout),
            .c_msb (sl_cmsb)
        );

        // NOTE: sequential state uses non-blocking assignments; data registers are
        // reset too so sum/cout/ovf read 0 straight after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv[k]) begin
                v_q <= in_v;
                if (in_v) begin
                    s_q <= s_nx;
                    c_q <= sl_cout;
                end
            end
        end

        assign stage_v[k] = v_q;

        if (k < STAGES - 1) begin : g_hi
            logic [REM-CW-1:0] ah_q;
            logic [REM-CW-1:0] bh_q;
            // Only the last slice's carry into the MSB feeds ovf.
            logic top_carry_unused;
            assign top_carry_unused = sl_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ah_q <= '0;
                    bh_q <= '0;
                end else if (adv[k] && in_v) begin
                    ah_q <= in_a[REM-1:CW];
                    bh_q <= in_b[REM-1:CW];
                end
            end
        end else begin : g_last
            logic cmsb_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)               cmsb_q <= 1'b0;
                else if (adv[k] && in_v)  cmsb_q <= sl_cmsb;
            end
        end
    end

    assign out_valid = stage_v[STAGES-1];
    assign sum       = g_st[STAGES-1].s_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign ovf       = g_st[STAGES-1].c_q ^ g_st[STAGES-1].g_last.cmsb_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca: directed cases on 32/4, random
// regressions on 8/1 and 64/8 against an arithmetic reference model.
module tb_pipelined_rca;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
    logic [31:0] a32, b32, s32;
    logic        iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
    logic [7:0]  a8, b8, s8;
    logic        iv64, ir64, cin64, sub64, ov64, or64, co64, of64;
    logic [63:0] a64, b64, s64;

    exp_t q32[$];
    exp_t q8[$];
    exp_t q64[$];

    int n_vec = 0;
    int n_err = 0;

    logic        acc32, last_ov32, last_ir32, last_co32, last_of32;
    logic [31:0] last_s32;

    pipelined_rca #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
        .cout(co32), .ovf(of32)
    );

    pipelined_rca #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(of8)
    );

    pipelined_rca #(.WIDTH(64), .STAGES(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64), .sum(s64),
        .cout(co64), .ovf(of64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sb, input int w);
        logic [65:0]        mask, ua, ub, r;
        logic signed [65:0] sa, sbv, t, lim;
        exp_t e;
        mask = (66'd1 << w) - 66'd1;
        ua   = {2'b00, a} & mask;
        ub   = {2'b00, b} & mask;
        sa   = $signed(ua);
        sbv  = $signed(ub);
        if (ua[w-1]) sa  = sa  - $signed(66'd1 << w);
        if (ub[w-1]) sbv = sbv - $signed(66'd1 << w);
        if (sb) begin
            r    = ua - ub;
            e.co = (ua >= ub);
            t    = sa - sbv;
        end else begin
            r    = ua + ub + {65'd0, ci};
            e.co = r[w];
            t    = sa + sbv + $signed({65'd0, ci});
        end
        e.s  = r[63:0] & mask[63:0];
        lim  = $signed(66'd1 << (w - 1));
        e.ov = (t >= lim) || (t < -lim);
        return e;
    endfunction

    task automatic score(input string tag, input int d, input logic ov, input logic ordy,
                         input logic iv, input logic ir, input logic [63:0] s,
                         input logic co, input logic of, input logic [63:0] a,
                         input logic [63:0] b, input logic ci, input logic sb, input int w);
        exp_t e;
        int   n;
        n = (d == 0) ? q32.size() : (d == 1) ? q8.size() : q64.size();
        if (ov) begin
            if (n == 0) begin
                check({tag, "_spurious_valid"}, 64'(ov), 64'd0);
            end else begin
                e = (d == 0) ? q32[0] : (d == 1) ? q8[0] : q64[0];
                check({tag, "_sum"}, s, e.s);
                check({tag, "_cout"}, 64'(co), 64'(e.co));
                check({tag, "_ovf"}, 64'(of), 64'(e.ov));
                if (ordy) begin
                    case (d)
                        0:       void'(q32.pop_front());
                        1:       void'(q8.pop_front());
                        default: void'(q64.pop_front());
                    endcase
                end
            end
        end
        if (iv && ir) begin
            case (d)
                0:       q32.push_back(model(a, b, ci, sb, w));
                1:       q8.push_back(model(a, b, ci, sb, w));
                default: q64.push_back(model(a, b, ci, sb, w));
            endcase
        end
    endtask

    // Called just after an edge with inputs set; observes, scores, advances one edge.
    task automatic tick();
        #1;
        acc32     = iv32 && ir32;
        last_ov32 = ov32;
        last_ir32 = ir32;
        last_s32  = s32;
        last_co32 = co32;
        last_of32 = of32;
        score("d32", 0, ov32, or32, iv32, ir32, 64'(s32), co32, of32, 64'(a32), 64'(b32), cin32, sub32, 32);
        score("d8",  1, ov8,  or8,  iv8,  ir8,  64'(s8),  co8,  of8,  64'(a8),  64'(b8),  cin8,  sub8,  8);
        score("d64", 2, ov64, or64, iv64, ir64, s64,      co64, of64, a64,      b64,      cin64, sub64, 64);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic sb, input logic [31:0] es,
                            input logic eco, input logic eof);
        int lat;
        a32 = a; b32 = b; cin32 = ci; sub32 = sb; iv32 = 1'b1; or32 = 1'b1;
        tick();
        check({tag, "_accept"}, 64'(acc32), 64'd1);
        iv32 = 1'b0;
        lat  = 0;
        do begin
            tick();
            lat++;
        end while (!last_ov32 && lat < 12);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_const_sum"}, 64'(last_s32), 64'(es));
        check({tag, "_const_cout"}, 64'(last_co32), 64'(eco));
        check({tag, "_const_ovf"}, 64'(last_of32), 64'(eof));
    endtask

    initial begin
        int sent;
        int emit_idx;

        rst_n = 1'b0;
        iv32 = 0; a32 = '0; b32 = '0; cin32 = 0; sub32 = 0; or32 = 1;
        iv8  = 0; a8  = '0; b8  = '0; cin8  = 0; sub8  = 0; or8  = 1;
        iv64 = 0; a64 = '0; b64 = '0; cin64 = 0; sub64 = 0; or64 = 1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(ov32), 64'd0);
        check("reset_sum", 64'(s32), 64'd0);
        check("reset_cout", 64'(co32), 64'd0);
        check("reset_ovf", 64'(of32), 64'd0);
        check("reset_out_valid_8", 64'(ov8), 64'd0);
        check("reset_out_valid_64", 64'(ov64), 64'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 64'(ir32), 64'd1);
        check("in_ready_after_reset_8", 64'(ir8), 64'd1);
        check("in_ready_after_reset_64", 64'(ir64), 64'd1);

        directed("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_borrow",  32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("add_cin",     32'd3, 32'd4, 1'b1, 1'b0, 32'd8, 1'b0, 1'b0);

        // Back-to-back stream with a four-cycle downstream stall.
        sent     = 0;
        emit_idx = 0;
        for (int c = 0; c < 40 && (sent < 8 || q32.size() != 0); c++) begin
            iv32  = (sent < 8);
            a32   = 32'(sent);
            b32   = 32'(sent);
            cin32 = 1'b0;
            sub32 = 1'b0;
            or32  = !(c >= 6 && c <= 9);
            tick();
            if (c == 6 || c == 9)
                check($sformatf("stream_in_ready_c%0d", c), 64'(last_ir32), 64'd0);
            if (c >= 6 && c <= 9)
                check("stream_stall_valid", 64'(last_ov32), 64'd1);
            if (last_ov32 && or32) begin
                check($sformatf("stream_order_%0d", emit_idx), 64'(last_s32), 64'(2 * emit_idx));
                emit_idx++;
            end
            sent += int'(acc32);
        end
        check("stream_sent", 64'(sent), 64'd8);
        check("stream_emitted", 64'(emit_idx), 64'd8);
        check("stream_drained", 64'(q32.size()), 64'd0);
        or32 = 1'b1;
        iv32 = 1'b0;

        directed("signed_ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("signed_ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Three beats in flight, then an asynchronous reset pulse.
        for (int i = 0; i < 3; i++) begin
            iv32 = 1'b1; a32 = 32'(100 + i); b32 = 32'd1; cin32 = 1'b0; sub32 = 1'b0;
            tick();
            check($sformatf("inflight_accept_%0d", i), 64'(acc32), 64'd1);
        end
        iv32  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(ov32), 64'd0);
        check("midreset_sum", 64'(s32), 64'd0);
        check("midreset_cout", 64'(co32), 64'd0);
        check("midreset_ovf", 64'(of32), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q32.delete();
        q8.delete();
        q64.delete();
        repeat (6) tick();
        directed("post_reset", 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_1235, 1'b0, 1'b0);

        // Random regression on all three configurations with random backpressure.
        for (int c = 0; c < 300; c++) begin
            iv32 = ($urandom_range(0, 3) != 0); a32 = $urandom; b32 = $urandom;
            cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
            or32 = ($urandom_range(0, 3) != 0);
            iv8 = ($urandom_range(0, 3) != 0); a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
            or8 = ($urandom_range(0, 3) != 0);
            iv64 = ($urandom_range(0, 3) != 0); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            cin64 = 1'($urandom_range(0, 1)); sub64 = 1'($urandom_range(0, 1));
            or64 = ($urandom_range(0, 3) != 0);
            tick();
        end
        iv32 = 0; iv8 = 0; iv64 = 0;
        or32 = 1; or8 = 1; or64 = 1;
        repeat (20) tick();
        check("random_drained_32", 64'(q32.size()), 64'd0);
        check("random_drained_8", 64'(q8.size()), 64'd0);
        check("random_drained_64", 64'(q64.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
